// File: rtl/inst_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : inst_mem_pkg                                                  |
// | Brief    : Shared types and helpers for the instruction memory slice     |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
package inst_mem_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

  // Loader state encodings
  typedef enum logic [1:0] {
    LD_IDLE = 2'b00,
    LD_LOAD = 2'b01,
    LD_DONE = 2'b10,
    LD_ERR  = 2'b11
  } ld_state_e;

  // Merge byte k of a little-endian stream onto the partially assembled word.
  // Bytes above position k are zero so a short final word is zero-padded.
  function automatic logic [31:0] merge_byte(input logic [23:0] asm_in,
                                             input logic [7:0]  b,
                                             input logic [1:0]  k);
    logic [31:0] w;
    w = 32'h0;
    case (k)
      2'd0:    w = {24'h0, b};
      2'd1:    w = {16'h0, b, asm_in[7:0]};
      2'd2:    w = {8'h0,  b, asm_in[15:0]};
      default: w = {b, asm_in};
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : inst_mem_if                                                   |
// | Brief    : Fetch port and byte-stream loader port of the inst memory     |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
interface inst_mem_if;
  // Fetch port (core PC stage)
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  // Program loader byte stream
  logic        ld_start_i;
  logic        ld_valid_i;
  logic [7:0]  ld_byte_i;
  logic        ld_last_i;
  logic        ld_ready_o;

  modport master (
    output ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
    input  inst_o, ld_ready_o
  );

  modport slave (
    input  ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
    output inst_o, ld_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : inst_loader                                                   |
// | Brief    : Byte-stream program loader: FSM, counters, word assembler     |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module inst_loader
  import inst_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             i_start,
  input  wire logic             i_valid,
  input  wire logic [7:0]       i_byte,
  input  wire logic             i_last,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_hold,
  output logic                  o_loading,
  output logic                  o_wr_en,
  output logic [IDX_W-1:0]      o_wr_idx,
  output logic [INST_W-1:0]     o_wr_data
);

  // word_ptr carries one extra bit so a full array is representable
  localparam logic [IDX_W:0] c_ptr_full = (IDX_W+1)'(DEPTH_WORDS);

  ld_state_e        r_state;
  ld_state_e        w_state_nxt;
  logic [1:0]       r_byte_cnt;
  logic [IDX_W:0]   r_word_ptr;
  logic [23:0]      r_asm;

  logic             w_accept;
  logic             w_wr_trig;
  logic             w_overflow;
  logic [31:0]      w_word;

  // A restart in LOAD drops whatever byte is offered in the same cycle
  assign w_accept   = i_valid && (r_state == LD_LOAD) && !i_start;
  assign w_word     = merge_byte(r_asm, i_byte, r_byte_cnt);
  assign w_wr_trig  = w_accept && ((r_byte_cnt == 2'd3) || i_last);
  assign w_overflow = w_wr_trig && (r_word_ptr == c_ptr_full);

  assign o_wr_en    = w_wr_trig && !w_overflow;
  assign o_wr_idx   = r_word_ptr[IDX_W-1:0];
  assign o_wr_data  = w_word;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= LD_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and status outputs decoded from the current state
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_hold      = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_loading   = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (i_start) w_state_nxt = LD_LOAD;
      end
      LD_LOAD: begin
        o_ready   = 1'b1;
        o_hold    = 1'b1;
        o_loading = 1'b1;
        if (i_start)                 w_state_nxt = LD_LOAD;
        else if (w_overflow)         w_state_nxt = LD_ERR;
        else if (w_accept && i_last) w_state_nxt = LD_DONE;
      end
      LD_DONE: begin
        o_done = 1'b1;
        if (i_start) w_state_nxt = LD_LOAD;
      end
      LD_ERR: begin
        o_err  = 1'b1;
        o_hold = 1'b1;
        if (i_start) w_state_nxt = LD_LOAD;
      end
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  // Byte counter, word pointer and assembly register
  always_ff @(posedge clk_i) begin
    if (rst_i || i_start) begin
      r_byte_cnt <= 2'd0;
      r_word_ptr <= '0;
      r_asm      <= '0;
    end else if (w_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      if (w_wr_trig) begin
        r_asm <= '0;
        if (!w_overflow) r_word_ptr <= r_word_ptr + 1'b1;
      end else begin
        r_asm <= w_word[23:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : inst_mem                                                      |
// | Brief    : Instruction memory with zero-latency fetch and byte loader    |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          IDX_W       = 10,
  parameter logic [31:0] NOP_INST    = NOP_INST_DEF
) (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  inst_mem_if.slave  bus,
  output logic       ld_done_o,
  output logic       ld_err_o,
  output logic       core_hold_o
);

  logic [INST_W-1:0] r_mem [DEPTH_WORDS];

  logic              w_loading;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [INST_W-1:0] w_wr_data;
  logic              w_in_range;
  logic              w_unused_lsb;

  inst_loader #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_loader (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_start   (bus.ld_start_i),
    .i_valid   (bus.ld_valid_i),
    .i_byte    (bus.ld_byte_i),
    .i_last    (bus.ld_last_i),
    .o_ready   (bus.ld_ready_o),
    .o_done    (ld_done_o),
    .o_err     (ld_err_o),
    .o_hold    (core_hold_o),
    .o_loading (w_loading),
    .o_wr_en   (w_wr_en),
    .o_wr_idx  (w_wr_idx),
    .o_wr_data (w_wr_data)
  );

  // Fetches are word aligned; the byte offset is intentionally ignored
  assign w_unused_lsb = ^bus.addr_i[1:0];
  assign w_in_range   = (bus.addr_i[31:IDX_W+2] == '0);

  // Array write port; contents survive reset so a loaded image persists
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
  end

  // Combinational fetch; NOP while loading, disabled or out of range
  always_comb begin
    bus.inst_o = NOP_INST;
    if (bus.ce_i && !w_loading && w_in_range)
      bus.inst_o = r_mem[bus.addr_i[IDX_W+1:2]];
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_inst_mem                                                   |
// | Brief    : Directed self-checking bench for inst_mem                     |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module tb_inst_mem;

  logic clk = 1'b0;
  logic rst, rst_s;
  logic done, err, hold;
  logic done_s, err_s, hold_s;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  inst_mem_if bus();
  inst_mem_if bus_s();

  inst_mem #(.DEPTH_WORDS(1024), .IDX_W(10), .NOP_INST(32'h0000_0013)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .ld_done_o(done), .ld_err_o(err), .core_hold_o(hold)
  );

  inst_mem #(.DEPTH_WORDS(4), .IDX_W(2), .NOP_INST(32'h0000_0013)) u_small (
    .clk_i(clk), .rst_i(rst_s), .bus(bus_s),
    .ld_done_o(done_s), .ld_err_o(err_s), .core_hold_o(hold_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.ld_valid_i = 1'b1; bus.ld_byte_i = b; bus.ld_last_i = last;
    tick();
    bus.ld_valid_i = 1'b0; bus.ld_last_i = 1'b0;
  endtask

  task automatic pulse_start();
    bus.ld_start_i = 1'b1;
    tick();
    bus.ld_start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_s = 1'b1;
    tick(); tick();
    rst = 1'b0; rst_s = 1'b0;
    tick();
    n_checks++; if (bus.ld_ready_o !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b exp 0", bus.ld_ready_o); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b exp 0", done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b exp 0", err); end
    n_checks++; if (hold !== 1'b0) begin n_errors++; $display("FAIL rst_hold: got %b exp 0", hold); end
    bus.ce_i = 1'b0; bus.addr_i = 32'h0; #1;
    n_checks++; if (bus.inst_o !== 32'h0000_0013) begin n_errors++; $display("FAIL rst_ce0_nop: got %h exp 00000013", bus.inst_o); end
  endtask

  task automatic test_load8();
    logic [7:0] img [8];
    img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    pulse_start();
    n_checks++; if (bus.ld_ready_o !== 1'b1) begin n_errors++; $display("FAIL load_ready: got %b exp 1", bus.ld_ready_o); end
    n_checks++; if (hold !== 1'b1) begin n_errors++; $display("FAIL load_hold: got %b exp 1", hold); end
    bus.ce_i = 1'b1; bus.addr_i = 32'h0; #1;
    n_checks++; if (bus.inst_o !== 32'h0000_0013) begin n_errors++; $display("FAIL fetch_in_load: got %h exp 00000013", bus.inst_o); end
    for (int i = 0; i < 8; i++) send_byte(img[i], (i == 7));
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL load8_done: got %b exp 1", done); end
    n_checks++; if (hold !== 1'b0) begin n_errors++; $display("FAIL load8_hold: got %b exp 0", hold); end
    n_checks++; if (bus.ld_ready_o !== 1'b0) begin n_errors++; $display("FAIL load8_ready: got %b exp 0", bus.ld_ready_o); end
    bus.addr_i = 32'h0; #1;
    n_checks++; if (bus.inst_o !== 32'h0010_0513) begin n_errors++; $display("FAIL load8_w0: got %h exp 00100513", bus.inst_o); end
    bus.addr_i = 32'h4; #1;
    n_checks++; if (bus.inst_o !== 32'h0020_0593) begin n_errors++; $display("FAIL load8_w1: got %h exp 00200593", bus.inst_o); end
    bus.addr_i = 32'h6; #1;
    n_checks++; if (bus.inst_o !== 32'h0020_0593) begin n_errors++; $display("FAIL addr6_w1: got %h exp 00200593", bus.inst_o); end
  endtask

  task automatic test_load5();
    logic [7:0] img [5];
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    pulse_start();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL restart_done_clr: got %b exp 0", done); end
    for (int i = 0; i < 5; i++) send_byte(img[i], (i == 4));
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL load5_done: got %b exp 1", done); end
    bus.addr_i = 32'h4; #1;
    n_checks++; if (bus.inst_o !== 32'h0000_0011) begin n_errors++; $display("FAIL load5_w1: got %h exp 00000011", bus.inst_o); end
    bus.addr_i = 32'h0; #1;
    n_checks++; if (bus.inst_o !== 32'hDDCC_BBAA) begin n_errors++; $display("FAIL load5_w0: got %h exp ddccbbaa", bus.inst_o); end
    bus.addr_i = 32'h0000_1000; #1;
    n_checks++; if (bus.inst_o !== 32'h0000_0013) begin n_errors++; $display("FAIL out_of_range: got %h exp 00000013", bus.inst_o); end
    bus.addr_i = 32'h4; bus.ce_i = 1'b0; #1;
    n_checks++; if (bus.inst_o !== 32'h0000_0013) begin n_errors++; $display("FAIL ce0_nop: got %h exp 00000013", bus.inst_o); end
    bus.ce_i = 1'b1;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w [4];
    exp_w = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};
    bus_s.ld_start_i = 1'b1; tick(); bus_s.ld_start_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      bus_s.ld_valid_i = 1'b1; bus_s.ld_byte_i = 8'(i); bus_s.ld_last_i = 1'b0;
      tick();
      bus_s.ld_valid_i = 1'b0;
      if (i == 19) begin
        n_checks++; if (err_s !== 1'b0) begin n_errors++; $display("FAIL ovf_early_err: got %b exp 0", err_s); end
      end
    end
    n_checks++; if (err_s !== 1'b1) begin n_errors++; $display("FAIL ovf_err: got %b exp 1", err_s); end
    n_checks++; if (hold_s !== 1'b1) begin n_errors++; $display("FAIL ovf_hold: got %b exp 1", hold_s); end
    n_checks++; if (bus_s.ld_ready_o !== 1'b0) begin n_errors++; $display("FAIL ovf_ready: got %b exp 0", bus_s.ld_ready_o); end
    bus_s.ce_i = 1'b1;
    for (int w = 0; w < 4; w++) begin
      bus_s.addr_i = 32'(w * 4); #1;
      n_checks++; if (bus_s.inst_o !== exp_w[w]) begin n_errors++; $display("FAIL ovf_mem%0d: got %h exp %h", w, bus_s.inst_o, exp_w[w]); end
    end
    bus_s.addr_i = 32'h10; #1;
    n_checks++; if (bus_s.inst_o !== 32'h0000_0013) begin n_errors++; $display("FAIL small_range: got %h exp 00000013", bus_s.inst_o); end
    bus_s.ld_start_i = 1'b1; tick(); bus_s.ld_start_i = 1'b0;
    n_checks++; if (err_s !== 1'b0) begin n_errors++; $display("FAIL ovf_restart_err: got %b exp 0", err_s); end
    n_checks++; if (bus_s.ld_ready_o !== 1'b1) begin n_errors++; $display("FAIL ovf_restart_ready: got %b exp 1", bus_s.ld_ready_o); end
  endtask

  task automatic test_rst_mid();
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (bus.ld_ready_o !== 1'b0) begin n_errors++; $display("FAIL midrst_ready: got %b exp 0", bus.ld_ready_o); end
    n_checks++; if (hold !== 1'b0) begin n_errors++; $display("FAIL midrst_hold: got %b exp 0", hold); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL midrst_done: got %b exp 0", done); end
    bus.addr_i = 32'h0; #1;
    n_checks++; if (bus.inst_o !== 32'h0403_0201) begin n_errors++; $display("FAIL midrst_w0: got %h exp 04030201", bus.inst_o); end
    bus.addr_i = 32'h4; #1;
    n_checks++; if (bus.inst_o !== 32'h0000_0011) begin n_errors++; $display("FAIL midrst_w1: got %h exp 00000011", bus.inst_o); end
  endtask

  task automatic test_back_to_back();
    // Bytes offered outside LOAD must not write anything
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b1);
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL idle_valid_done: got %b exp 0", done); end
    bus.addr_i = 32'h0; #1;
    n_checks++; if (bus.inst_o !== 32'h0403_0201) begin n_errors++; $display("FAIL idle_valid_w0: got %h exp 04030201", bus.inst_o); end
    // Start with a byte in IDLE drops the byte; restart in LOAD drops the partial word
    bus.ld_start_i = 1'b1; send_byte(8'h77, 1'b0); bus.ld_start_i = 1'b0;
    send_byte(8'h01, 1'b0);
    bus.ld_start_i = 1'b1; send_byte(8'h99, 1'b0); bus.ld_start_i = 1'b0;
    send_byte(8'h55, 1'b1);
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_done: got %b exp 1", done); end
    bus.addr_i = 32'h0; #1;
    n_checks++; if (bus.inst_o !== 32'h0000_0055) begin n_errors++; $display("FAIL b2b_w0: got %h exp 00000055", bus.inst_o); end
  endtask

  initial begin
    rst = 1'b1; rst_s = 1'b1;
    bus.ce_i = 1'b0; bus.addr_i = 32'h0; bus.ld_start_i = 1'b0;
    bus.ld_valid_i = 1'b0; bus.ld_byte_i = 8'h0; bus.ld_last_i = 1'b0;
    bus_s.ce_i = 1'b0; bus_s.addr_i = 32'h0; bus_s.ld_start_i = 1'b0;
    bus_s.ld_valid_i = 1'b0; bus_s.ld_byte_i = 8'h0; bus_s.ld_last_i = 1'b0;
    test_reset();
    test_load8();
    test_load5();
    test_overflow();
    test_rst_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
